// File: rtl/vec_tx_pkg.sv
// vec_tx_pkg: shared types and helpers for the vec_stream_tx slice.
//   state_t : FSM encoding (IDLE, SEND).
//   vec_t   : unpacked DATA_W x COLS vector for the default build
//             (VEC_DATA_W x VEC_COLS).
//   idx_w() : element-index width for a given vector length.
package vec_tx_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int VEC_COLS   = 4;
  localparam int VEC_DATA_W = 32;

  typedef logic [VEC_DATA_W-1:0] vec_t [0:VEC_COLS-1];

  // Width of an index that addresses cols elements (cols >= 2).
  function automatic int idx_w(input int cols);
    return $clog2(cols);
  endfunction

endpackage

// File: rtl/vec_tx_buf.sv
// vec_tx_buf: one vector register bank with a whole-vector load port and a
// single indexed read port.
// Ports:
//   clk, rst       clock, asynchronous active-low reset (clears the bank)
//   ld_en, ld_data load all COLS elements in one cycle
//   rd_idx         element to read (0..COLS-1)
//   rd_data        combinational read of the stored element
module vec_tx_buf
  import vec_tx_pkg::*;
#(
  parameter int COLS   = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = idx_w(COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [DATA_W-1:0] ld_data [0:COLS-1],
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [0:COLS-1];

  // Vector storage: cleared on reset, replaced wholesale on a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < COLS; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (ld_en) begin
      for (int i = 0; i < COLS; i++) begin
        mem_r[i] <= ld_data[i];
      end
    end
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/vec_stream_tx.sv
// vec_stream_tx: accepts one COLS-element vector through a valid/ready load
// port and serialises it onto an AXI4-Stream master, element 0 first, with
// TLAST on element COLS-1.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   vec_in/vec_valid/vec_ready   parallel vector load handshake
//   OUTPUT_AXIS_*        AXI4-Stream master (TDATA, TLAST, TVALID, TREADY)
//   frames_sent          completed frames (TLAST handshakes), wraps
//   busy                 high while a frame is being sent
// Build option: define VEC_TX_PREFETCH_EN to add a spare (ping-pong) buffer
// so a following vector can be loaded while sending, giving gapless frames.
module vec_stream_tx
  import vec_tx_pkg::*;
#(
  parameter int COLS   = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] vec_in [0:COLS-1],
  input  logic              vec_valid,
  output logic              vec_ready,
  output logic [DATA_W-1:0] OUTPUT_AXIS_TDATA,
  output logic              OUTPUT_AXIS_TLAST,
  output logic              OUTPUT_AXIS_TVALID,
  input  logic              OUTPUT_AXIS_TREADY,
  output logic [CNT_W-1:0]  frames_sent,
  output logic              busy
);

  localparam int               IDX_W    = idx_w(COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COLS - 1);

  state_t            state_r, state_n_s;
  logic [IDX_W-1:0]  idx_r, idx_n_s, idx_inc_s;
  logic              tvalid_r, tvalid_n_s;
  logic              tlast_r, tlast_n_s;
  logic [DATA_W-1:0] tdata_r, tdata_n_s;
  logic              vec_ready_r, vec_ready_n_s;
  logic              busy_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              cnt_inc_s;
  logic              load_hs_s, beat_hs_s;
  logic [DATA_W-1:0] act_rd_s;

  assign load_hs_s = vec_valid & vec_ready_r;
  assign beat_hs_s = tvalid_r & OUTPUT_AXIS_TREADY;
  // Index of the element that follows the one currently on the bus.
  assign idx_inc_s = (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);

`ifdef VEC_TX_PREFETCH_EN
  logic              act_r;          // which bank is being sent
  logic              spare_full_r, spare_full_n_s;
  logic              last_hs_s, swap_s, ld_tgt_s;
  logic [IDX_W-1:0]  rd_idx0_s, rd_idx1_s;
  logic [DATA_W-1:0] rd0_s, rd1_s, spare_rd_s;

  assign last_hs_s = beat_hs_s & tlast_r;
  // A finished frame chains straight into the next one if a vector is
  // waiting in the spare bank or is arriving on this very edge.
  assign swap_s    = last_hs_s & (spare_full_r | load_hs_s);
  // When idle both banks are empty, so the load goes to the active bank.
  assign ld_tgt_s  = (state_r == IDLE) ? act_r : ~act_r;

  // The spare bank is only ever read at element 0 (first beat after a swap).
  assign rd_idx0_s  = act_r ? {IDX_W{1'b0}} : idx_inc_s;
  assign rd_idx1_s  = act_r ? idx_inc_s : {IDX_W{1'b0}};
  assign act_rd_s   = act_r ? rd1_s : rd0_s;
  assign spare_rd_s = act_r ? rd0_s : rd1_s;

  vec_tx_buf #(.COLS(COLS), .DATA_W(DATA_W)) u_buf0 (
    .clk     (clk),
    .rst     (rst),
    .ld_en   (load_hs_s & ~ld_tgt_s),
    .ld_data (vec_in),
    .rd_idx  (rd_idx0_s),
    .rd_data (rd0_s)
  );

  vec_tx_buf #(.COLS(COLS), .DATA_W(DATA_W)) u_buf1 (
    .clk     (clk),
    .rst     (rst),
    .ld_en   (load_hs_s & ld_tgt_s),
    .ld_data (vec_in),
    .rd_idx  (rd_idx1_s),
    .rd_data (rd1_s)
  );

  // Spare-bank occupancy: filled by a load during SEND, emptied by a swap.
  always_comb begin
    spare_full_n_s = spare_full_r;
    if (swap_s) begin
      spare_full_n_s = 1'b0;
    end else if (load_hs_s && (state_r == SEND)) begin
      spare_full_n_s = 1'b1;
    end else begin
      spare_full_n_s = spare_full_r;
    end
  end

  // Loads are accepted whenever the spare bank will be empty.
  assign vec_ready_n_s = ~spare_full_n_s;
`else
  vec_tx_buf #(.COLS(COLS), .DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .ld_en   (load_hs_s),
    .ld_data (vec_in),
    .rd_idx  (idx_inc_s),
    .rd_data (act_rd_s)
  );

  // Single bank: loads only while idle.
  assign vec_ready_n_s = (state_n_s == IDLE);
`endif

  // FSM next state and next values of the registered stream outputs.
  always_comb begin
    state_n_s  = state_r;
    idx_n_s    = idx_r;
    tvalid_n_s = tvalid_r;
    tlast_n_s  = tlast_r;
    tdata_n_s  = tdata_r;
    cnt_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_hs_s) begin
          // Element 0 comes straight from the input so it is on the bus in
          // the cycle after the load.
          state_n_s  = SEND;
          idx_n_s    = {IDX_W{1'b0}};
          tvalid_n_s = 1'b1;
          tlast_n_s  = 1'b0;
          tdata_n_s  = vec_in[0];
        end else begin
          tvalid_n_s = 1'b0;
          tlast_n_s  = 1'b0;
        end
      end
      SEND: begin
        if (beat_hs_s && tlast_r) begin
          cnt_inc_s = 1'b1;
`ifdef VEC_TX_PREFETCH_EN
          if (swap_s) begin
            idx_n_s    = {IDX_W{1'b0}};
            tvalid_n_s = 1'b1;
            tlast_n_s  = 1'b0;
            if (spare_full_r) begin
              tdata_n_s = spare_rd_s;
            end else begin
              tdata_n_s = vec_in[0];
            end
          end else begin
            state_n_s  = IDLE;
            tvalid_n_s = 1'b0;
            tlast_n_s  = 1'b0;
          end
`else
          state_n_s  = IDLE;
          tvalid_n_s = 1'b0;
          tlast_n_s  = 1'b0;
`endif
        end else if (beat_hs_s) begin
          idx_n_s   = idx_inc_s;
          tdata_n_s = act_rd_s;
          tlast_n_s = (idx_inc_s == LAST_IDX);
        end else begin
          // No handshake: everything on the bus holds.
          tvalid_n_s = 1'b1;
        end
      end
      default: begin
        state_n_s  = IDLE;
        tvalid_n_s = 1'b0;
        tlast_n_s  = 1'b0;
      end
    endcase
  end

  // State, index, output and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      tdata_r     <= {DATA_W{1'b0}};
      vec_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
`ifdef VEC_TX_PREFETCH_EN
      act_r        <= 1'b0;
      spare_full_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_n_s;
      idx_r       <= idx_n_s;
      tvalid_r    <= tvalid_n_s;
      tlast_r     <= tlast_n_s;
      tdata_r     <= tdata_n_s;
      vec_ready_r <= vec_ready_n_s;
      busy_r      <= (state_n_s == SEND);
      cnt_r       <= cnt_inc_s ? cnt_r + CNT_W'(1) : cnt_r;
`ifdef VEC_TX_PREFETCH_EN
      act_r        <= swap_s ? ~act_r : act_r;
      spare_full_r <= spare_full_n_s;
`endif
    end
  end

  assign vec_ready          = vec_ready_r;
  assign OUTPUT_AXIS_TDATA  = tdata_r;
  assign OUTPUT_AXIS_TLAST  = tlast_r;
  assign OUTPUT_AXIS_TVALID = tvalid_r;
  assign frames_sent        = cnt_r;
  assign busy               = busy_r;

endmodule

// File: tb/tb_vec_stream_tx.sv
// tb_vec_stream_tx: directed bench for vec_stream_tx (COLS=4, DATA_W=32,
// CNT_W=2). A queue-based model holds every word still owed on the stream;
// the compare process checks the DUT against it on every cycle, and
// literal expectations pin the model at key points.
module tb_vec_stream_tx;
  import vec_tx_pkg::*;

  localparam int COLS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  vec_t        vin;
  logic        vec_valid = 1'b0;
  logic        vec_ready;
  logic [31:0] tdata;
  logic        tlast, tvalid;
  logic        tready = 1'b1;
  logic [1:0]  frames;
  logic        busy;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  vec_stream_tx #(.COLS(COLS), .DATA_W(32), .CNT_W(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .vec_in             (vin),
    .vec_valid          (vec_valid),
    .vec_ready          (vec_ready),
    .OUTPUT_AXIS_TDATA  (tdata),
    .OUTPUT_AXIS_TLAST  (tlast),
    .OUTPUT_AXIS_TVALID (tvalid),
    .OUTPUT_AXIS_TREADY (tready),
    .frames_sent        (frames),
    .busy               (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Model: words still to be sent (current frame remainder + queued frames).
  logic [31:0] m_q[$];
  logic        m_rdy = 1'b0;
  logic [1:0]  m_cnt = 2'd0;
  bit          m_tv, m_last, m_beat, m_load;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_q.delete();
      m_rdy = 1'b0;
      m_cnt = 2'd0;
    end else begin
      m_tv   = (m_q.size() > 0);
      m_last = m_tv && ((m_q.size() % COLS) == 1);
      m_beat = m_tv && tready;
      m_load = vec_valid && m_rdy;
      if (m_beat) begin
        if (m_last) m_cnt++;
        void'(m_q.pop_front());
      end
      if (m_load) begin
        for (int i = 0; i < COLS; i++) m_q.push_back(vin[i]);
      end
`ifdef VEC_TX_PREFETCH_EN
      m_rdy = (m_q.size() <= COLS);
`else
      m_rdy = (m_q.size() == 0);
`endif
    end
  end

  // Compare process: every cycle, mid-period.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_tvalid", 32'(tvalid), 32'd0);
      chk("rst_tlast", 32'(tlast), 32'd0);
      chk("rst_tdata", tdata, 32'd0);
      chk("rst_vec_ready", 32'(vec_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frames", 32'(frames), 32'd0);
    end else begin
      chk("tvalid", 32'(tvalid), 32'(m_q.size() > 0));
      chk("busy", 32'(busy), 32'(m_q.size() > 0));
      chk("vec_ready", 32'(vec_ready), 32'(m_rdy));
      chk("frames_sent", 32'(frames), 32'(m_cnt));
      if (m_q.size() > 0) begin
        chk("tdata", tdata, m_q[0]);
        chk("tlast", 32'(tlast), 32'((m_q.size() % COLS) == 1));
      end else begin
        chk("tlast_idle", 32'(tlast), 32'd0);
      end
    end
  end

  // TREADY driver and beat recorder (a beat is pending when TVALID&&TREADY
  // hold mid-cycle; it completes on the next rising edge).
  int          rdy_mode = 0;
  int          cyc = 0;
  logic [31:0] obs_d[$];
  int          obs_c[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rdy_mode == 0) tready = 1'b1;
    else tready = ((cyc % 3) == 0);
    if (rst && tvalid && tready) begin
      obs_d.push_back(tdata);
      obs_c.push_back(cyc);
    end
  end

  task automatic load_vec(input logic [31:0] a, b, c, d);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        vin[0] = a; vin[1] = b; vin[2] = c; vin[3] = d;
        vec_valid = 1'b1;
      end
      if (vec_ready) got = 1'b1;
    end
    chk("load_handshake_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1 vec_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (m_q.size() == 0 && m_rdy) done = 1'b1;
    end
    chk("idle_reached", 32'(done), 32'd1);
  endtask

  int base;
  int exp_wrap [5] = '{1, 2, 3, 0, 1};
  bit hit;

  initial begin
    vin = '{32'd0, 32'd0, 32'd0, 32'd0};
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(vec_ready), 32'd1);

    // Basic frame.
    base = obs_d.size();
    load_vec(32'd1, 32'd2, 32'd3, 32'd4);
    wait_idle();
    for (int k = 0; k < 4; k++) chk("basic_beat", obs_d[base+k], 32'(k + 1));
    chk("basic_frames", 32'(frames), 32'd1);
    chk("basic_ready", 32'(vec_ready), 32'd1);

    // Backpressure.
    rdy_mode = 1;
    base = obs_d.size();
    load_vec(32'd1, 32'd2, 32'd3, 32'd4);
    wait_idle();
    rdy_mode = 0;
    chk("bp_beats", 32'(obs_d.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) chk("bp_beat", obs_d[base+k], 32'(k + 1));
    chk("bp_frames", 32'(frames), 32'd2);

    // Back-to-back loads.
    base = obs_d.size();
    load_vec(32'd10, 32'd11, 32'd12, 32'd13);
    load_vec(32'd20, 32'd21, 32'd22, 32'd23);
    wait_idle();
    chk("b2b_beats", 32'(obs_d.size() - base), 32'd8);
    for (int k = 0; k < 4; k++) begin
      chk("b2b_f1", obs_d[base+k], 32'(10 + k));
      chk("b2b_f2", obs_d[base+4+k], 32'(20 + k));
    end
`ifdef VEC_TX_PREFETCH_EN
    chk("b2b_gap", 32'(obs_c[base+7] - obs_c[base] - 7), 32'd0);
`else
    chk("b2b_gap", 32'(obs_c[base+7] - obs_c[base] - 7), 32'd1);
`endif
    chk("b2b_frames", 32'(frames), 32'd0);

    // Load request while busy is ignored.
    rdy_mode = 1;
    base = obs_d.size();
    load_vec(32'd1, 32'd2, 32'd3, 32'd4);
`ifndef VEC_TX_PREFETCH_EN
    @(negedge clk);
    vin = '{32'd9, 32'd9, 32'd9, 32'd9};
    vec_valid = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
`endif
    wait_idle();
    rdy_mode = 0;
    chk("busy_beats", 32'(obs_d.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) chk("busy_beat", obs_d[base+k], 32'(k + 1));
    chk("busy_frames", 32'(frames), 32'd1);

    // Asynchronous reset after beat 2.
    base = obs_d.size();
    load_vec(32'd5, 32'd6, 32'd7, 32'd8);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (obs_d.size() >= base + 2) hit = 1'b1;
    end
    chk("reset_beat2_seen", 32'(hit), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_tvalid", 32'(tvalid), 32'd0);
    chk("async_frames", 32'(frames), 32'd0);
    chk("async_beats", 32'(obs_d.size() - base), 32'd2);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Restart, then counter wrap with CNT_W=2.
    base = obs_d.size();
    load_vec(32'd1, 32'd2, 32'd3, 32'd4);
    wait_idle();
    chk("restart_first", obs_d[base], 32'd1);
    chk("wrap_0", 32'(frames), 32'(exp_wrap[0]));
    for (int k = 1; k < 5; k++) begin
      load_vec(32'(k * 100), 32'(k * 100 + 1), 32'(k * 100 + 2), 32'(k * 100 + 3));
      wait_idle();
      chk("wrap_k", 32'(frames), 32'(exp_wrap[k]));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

endmodule
